// File: rtl/updown_decoder_pkg.sv
// Shared types and constants for the up/down pump pulse decoder.
package updown_decoder_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StMeasure,
      StScale,
      StHold
   } state_e;

   localparam int unsigned ARM_CYCLES = 2;

   // Synced pair is packed as {up_n, down_n}; both pulses are active-low.
   localparam logic [1:0] UP_ACTIVE    = 2'b01;
   localparam logic [1:0] DN_ACTIVE    = 2'b10;
   localparam logic [1:0] IDLE_PAIR    = 2'b11;
   localparam logic [1:0] ILLEGAL_PAIR = 2'b00;

   function automatic bit params_legal(input int unsigned win_log2,
                                       input int unsigned cnt_w,
                                       input int unsigned out_w);
      return (cnt_w >= win_log2 + 2) && (out_w >= cnt_w + 15);
   endfunction

endpackage

// File: rtl/updown_sync.sv
// Two-flop retimer for the active-low up/down pulse pair; resets to the inactive level.
module updown_sync
   import updown_decoder_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       up_n_i,
   input  logic       down_n_i,
   output logic [1:0] pair_o
);

   logic [1:0] meta_q;
   logic [1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= IDLE_PAIR;
         sync_q <= IDLE_PAIR;
      end else begin
         meta_q <= {up_n_i, down_n_i};
         sync_q <= meta_q;
      end
   end

   assign pair_o = sync_q;

endmodule

// File: rtl/updown_decoder.sv
// Counts up-minus-down pump cycles over a 2^WIN_LOG2 window, scales by the latched divider
// exponent and returns the signed estimate through a valid/ready handshake.
module updown_decoder
   import updown_decoder_pkg::*;
#(
   parameter int unsigned WIN_LOG2 = 16,
   parameter int unsigned CNT_W    = 24,
   parameter int unsigned OUT_W    = 40
) (
   input  logic                    CLK67MHZ,
   input  logic                    resetPort,
   input  logic                    upPort,
   input  logic                    downPort,
   input  logic [3:0]              shiftIn,
   input  logic                    startPort,
   input  logic                    readyIn,
   output logic signed [OUT_W-1:0] kvalOut,
   output logic                    validPort,
   output logic                    busyPort,
   output logic                    errPort
);

   if (!params_legal(WIN_LOG2, CNT_W, OUT_W)) begin : g_param_check
      $error("updown_decoder: illegal WIN_LOG2/CNT_W/OUT_W combination");
   end

   localparam int unsigned CntW = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
   localparam logic [CntW-1:0] WinLast = CntW'((1 << WIN_LOG2) - 1);
   localparam logic [CntW-1:0] ArmLast = CntW'(ARM_CYCLES - 1);

   state_e                    state_q, state_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic signed [CNT_W-1:0]   acc_q, acc_d;
   logic [3:0]                shift_q, shift_d;
   logic signed [OUT_W-1:0]   kval_q, kval_d;
   logic                      valid_q, valid_d;
   logic                      err_q, err_d;
   logic                      start_accept;
   logic [1:0]                pair;
   logic signed [OUT_W-1:0]   acc_ext;

   updown_sync u_sync (
      .clk_i    (CLK67MHZ),
      .rst_i    (resetPort),
      .up_n_i   (upPort),
      .down_n_i (downPort),
      .pair_o   (pair)
   );

   assign acc_ext = {{(OUT_W-CNT_W){acc_q[CNT_W-1]}}, acc_q};

   always_ff @(posedge CLK67MHZ) begin
      if (resetPort) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         shift_q <= '0;
         kval_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         shift_q <= shift_d;
         kval_q  <= kval_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      shift_d      = shift_q;
      kval_d       = kval_q;
      valid_d      = valid_q;
      err_d        = err_q;
      start_accept = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (startPort) start_accept = 1'b1;
         end
         StArm: begin
            if (cnt_q == ArmLast) begin
               cnt_d   = '0;
               state_d = StMeasure;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StMeasure: begin
            case (pair)
               UP_ACTIVE:    acc_d = acc_q + CNT_W'(1);
               DN_ACTIVE:    acc_d = acc_q - CNT_W'(1);
               ILLEGAL_PAIR: err_d = 1'b1;
               default:      acc_d = acc_q;
            endcase
            if (cnt_q == WinLast) begin
               cnt_d   = '0;
               state_d = StScale;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StScale: begin
            kval_d  = acc_ext <<< shift_q;
            valid_d = 1'b1;
            state_d = StHold;
         end
         StHold: begin
            if (valid_q && readyIn) begin
               valid_d = 1'b0;
               state_d = StIdle;
               if (startPort) start_accept = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // An accepted start overrides whatever the state decode chose.
      if (start_accept) begin
         state_d = StArm;
         cnt_d   = '0;
         acc_d   = '0;
         shift_d = shiftIn;
         err_d   = 1'b0;
      end
   end

   assign kvalOut   = kval_q;
   assign validPort = valid_q;
   assign busyPort  = (state_q != StIdle);
   assign errPort   = err_q;

endmodule

// File: tb/tb_updown_decoder.sv
// Directed self-checking bench for updown_decoder with a 16-cycle window.
module tb_updown_decoder;

   localparam int unsigned WinLog2 = 4;
   localparam int unsigned CntW    = 8;
   localparam int unsigned OutW    = 40;

   logic            clk = 1'b0;
   logic            resetPort;
   logic            upPort;
   logic            downPort;
   logic [3:0]      shiftIn;
   logic            startPort;
   logic            readyIn;
   logic [OutW-1:0] kvalOut;
   logic            validPort;
   logic            busyPort;
   logic            errPort;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   updown_decoder #(
      .WIN_LOG2 (WinLog2),
      .CNT_W    (CntW),
      .OUT_W    (OutW)
   ) dut (
      .CLK67MHZ  (clk),
      .resetPort (resetPort),
      .upPort    (upPort),
      .downPort  (downPort),
      .shiftIn   (shiftIn),
      .startPort (startPort),
      .readyIn   (readyIn),
      .kvalOut   (kvalOut),
      .validPort (validPort),
      .busyPort  (busyPort),
      .errPort   (errPort)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for validPort after a start edge; mode 1 toggles upPort, mode 2 injects an
   // illegal burst. lat counts edges since the start was sampled.
   task automatic wait_valid(input int mode, output int lat);
      lat = 1;
      while (!validPort && lat < 40) begin
         if (mode == 1) upPort = ~upPort;
         if (mode == 2) begin
            if (lat >= 6 && lat <= 8) {upPort, downPort} = 2'b00;
            else {upPort, downPort} = 2'b11;
         end
         tick();
         lat++;
      end
   endtask

   task automatic run_window(input logic [3:0] sh, input int mode, output int lat);
      shiftIn   = sh;
      startPort = 1'b1;
      tick();
      startPort = 1'b0;
      shiftIn   = ~sh;
      wait_valid(mode, lat);
   endtask

   task automatic accept(input string tag);
      readyIn = 1'b1;
      tick();
      readyIn = 1'b0;
      check_eq({tag, "_valid_drop"}, 64'(validPort), 64'd0);
      check_eq({tag, "_idle"}, 64'(busyPort), 64'd0);
   endtask

   initial begin
      int   lat;
      logic saw_valid;
      logic [OutW-1:0] held;

      resetPort = 1'b1;
      upPort    = 1'b1;
      downPort  = 1'b1;
      shiftIn   = 4'd0;
      startPort = 1'b0;
      readyIn   = 1'b0;
      tick();
      tick();
      check_eq("rst_kval", 64'(kvalOut), 64'd0);
      check_eq("rst_valid", 64'(validPort), 64'd0);
      check_eq("rst_busy", 64'(busyPort), 64'd0);
      check_eq("rst_err", 64'(errPort), 64'd0);
      resetPort = 1'b0;
      tick();

      // Up held, shift 0
      upPort   = 1'b0;
      downPort = 1'b1;
      run_window(4'd0, 0, lat);
      check_eq("up_latency", 64'(lat), 64'd20);
      check_eq("up_kval", 64'(kvalOut), 64'd16);
      check_eq("up_err", 64'(errPort), 64'd0);
      check_eq("up_busy", 64'(busyPort), 64'd1);
      accept("up");

      // Down held, shift 3
      upPort   = 1'b1;
      downPort = 1'b0;
      run_window(4'd3, 0, lat);
      check_eq("dn_latency", 64'(lat), 64'd20);
      check_eq("dn_kval", 64'(kvalOut), 64'h00FF_FFFF_FF80);
      accept("dn");

      // Up toggling, shift 15
      upPort   = 1'b0;
      downPort = 1'b1;
      run_window(4'd15, 1, lat);
      check_eq("tog_latency", 64'(lat), 64'd20);
      check_eq("tog_kval", 64'(kvalOut), 64'd262144);
      accept("tog");

      // Illegal burst inside MEASURE
      upPort   = 1'b1;
      downPort = 1'b1;
      run_window(4'd0, 2, lat);
      check_eq("ill_kval", 64'(kvalOut), 64'd0);
      check_eq("ill_err", 64'(errPort), 64'd1);
      accept("ill");
      check_eq("ill_err_sticky", 64'(errPort), 64'd1);
      startPort = 1'b1;
      tick();
      startPort = 1'b0;
      check_eq("ill_err_clear", 64'(errPort), 64'd0);
      check_eq("ill_busy", 64'(busyPort), 64'd1);
      wait_valid(0, lat);
      check_eq("ill2_kval", 64'(kvalOut), 64'd0);
      accept("ill2");

      // Long HOLD with an ignored start, then accept with start
      upPort   = 1'b1;
      downPort = 1'b0;
      run_window(4'd0, 0, lat);
      check_eq("hold_kval", 64'(kvalOut), 64'h00FF_FFFF_FFF0);
      held = kvalOut;
      for (int i = 0; i < 10; i++) begin
         startPort = (i == 4);
         tick();
         check_eq("hold_valid", 64'(validPort), 64'd1);
         check_eq("hold_stable", 64'(kvalOut), 64'(held));
      end
      startPort = 1'b0;
      upPort    = 1'b0;
      downPort  = 1'b1;
      shiftIn   = 4'd1;
      readyIn   = 1'b1;
      startPort = 1'b1;
      tick();
      readyIn   = 1'b0;
      startPort = 1'b0;
      shiftIn   = 4'd9;
      check_eq("rearm_valid", 64'(validPort), 64'd0);
      check_eq("rearm_busy", 64'(busyPort), 64'd1);
      wait_valid(0, lat);
      check_eq("rearm_latency", 64'(lat), 64'd20);
      check_eq("rearm_kval", 64'(kvalOut), 64'd32);
      accept("rearm");

      // Reset mid-MEASURE
      upPort    = 1'b0;
      downPort  = 1'b0;
      shiftIn   = 4'd2;
      startPort = 1'b1;
      tick();
      startPort = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check_eq("abort_busy_pre", 64'(busyPort), 64'd1);
      check_eq("abort_err_pre", 64'(errPort), 64'd1);
      resetPort = 1'b1;
      tick();
      resetPort = 1'b0;
      upPort    = 1'b1;
      downPort  = 1'b1;
      check_eq("abort_kval", 64'(kvalOut), 64'd0);
      check_eq("abort_valid", 64'(validPort), 64'd0);
      check_eq("abort_busy", 64'(busyPort), 64'd0);
      check_eq("abort_err", 64'(errPort), 64'd0);
      saw_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         saw_valid = saw_valid | validPort | busyPort;
      end
      check_eq("abort_no_output", 64'(saw_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
